// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_pkg;

    typedef enum logic [1:0] {
        PC_4   = 2'b00,
        BRANCH = 2'b01,
        JALR   = 2'b10,
        JAL    = 2'b11
    } branch_sel_e;

    localparam int LAT_W_DEF = 3;

    // Cycles until a result can be forwarded; 0 means no scoreboard entry.
    localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd1;
    localparam logic [LAT_W_DEF-1:0] LAT_MUL  = 3'd3;
    localparam logic [LAT_W_DEF-1:0] LAT_FP   = 3'd4;
    localparam logic [LAT_W_DEF-1:0] LAT_DIV  = 3'd6;

    typedef struct packed {
        logic pc_write;
        logic instr_flush;
        logic if_id_write;
        logic ctrl_flush;
    } hazard_ctrl_t;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard countdown counter: set beats clear beats decrement; hold freezes the countdown.
// State updates on the next clock edge; busy_o is a direct decode of the registered count.
module hazard_sb_entry #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic [LAT_W-1:0] set_val_i,
    input  logic             clr_i,
    input  logic             hold_i,
    output logic             busy_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (set_i) begin
            cnt_d = set_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '0 && !hold_i) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown hazard scoreboard driving PC, IF/ID and ID/EXE control; outputs combinational from ID inputs and counters.
// Optional stall performance counter behind HAZARD_PERF_CNT_EN (stall_cnt tied to 0 when undefined).
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = $clog2(REG_NUM),
    parameter int NUM_SRC = 3,
    parameter int LAT_W   = LAT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                branch_sel,
    input  logic                      mem_stall,
    input  logic                      id_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [ADDR_W-1:0]         id_rd_addr,
    input  logic                      id_rd_we,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic                      wb_clr_valid,
    input  logic [ADDR_W-1:0]         wb_clr_addr,
    output logic                      pc_write,
    output logic                      instr_flush,
    output logic                      IF_ID_reg_write,
    output logic                      ctrl_sig_flush,
    output logic                      lw_use,
    output logic [REG_NUM-1:0]        busy_vec,
    output logic [31:0]               stall_cnt
);

    logic         hazard;
    logic         branch_taken;
    logic         issue;
    logic         issue_wr;
    hazard_ctrl_t ctrl;

    assign branch_taken = (branch_sel != PC_4);

    // RAW on any enabled source, or WAW on the destination, against a live counter.
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (id_rs_used[s] && (id_rs_addr[s*ADDR_W +: ADDR_W] != '0)
                    && busy_vec[id_rs_addr[s*ADDR_W +: ADDR_W]]) begin
                    hazard = 1'b1;
                end
            end
            if (id_rd_we && (id_rd_addr != '0) && busy_vec[id_rd_addr]) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        ctrl   = '{pc_write: 1'b1, instr_flush: 1'b0, if_id_write: 1'b1, ctrl_flush: 1'b0};
        lw_use = 1'b0;
        if (mem_stall) begin
            ctrl = '{pc_write: 1'b0, instr_flush: 1'b0, if_id_write: 1'b0, ctrl_flush: 1'b0};
        end else if (branch_taken) begin
            ctrl = '{pc_write: 1'b1, instr_flush: 1'b1, if_id_write: 1'b1, ctrl_flush: 1'b1};
        end else if (hazard) begin
            ctrl   = '{pc_write: 1'b0, instr_flush: 1'b0, if_id_write: 1'b0, ctrl_flush: 1'b1};
            lw_use = 1'b1;
        end
    end

    assign pc_write        = ctrl.pc_write;
    assign instr_flush     = ctrl.instr_flush;
    assign IF_ID_reg_write = ctrl.if_id_write;
    assign ctrl_sig_flush  = ctrl.ctrl_flush;

    assign issue    = id_valid && !mem_stall && !branch_taken && !hazard;
    assign issue_wr = issue && id_rd_we && (id_rd_addr != '0) && (id_lat != '0);

    assign busy_vec[0] = 1'b0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_sb
        hazard_sb_entry #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .set_i    (issue_wr && (id_rd_addr == ADDR_W'(r))),
            .set_val_i(id_lat),
            .clr_i    (wb_clr_valid && (wb_clr_addr == ADDR_W'(r))),
            .hold_i   (mem_stall),
            .busy_o   (busy_vec[r])
        );
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (lw_use && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Next-generation pipeline hazard controller for the 5-stage core. It replaces pure single-load-use compare logic with a per-register countdown scoreboard, so loads, multi-cycle MUL/DIV and FP ops of any latency stall dependent instructions in ID. It also adds a global memory-stall freeze, WAW protection and a stall performance counter. It sits beside the ID stage and drives the PC, IF/ID and ID/EXE control.

Parameters:
REG_NUM, 32, number of architectural registers tracked (reg 0 never tracked)
ADDR_W, $clog2(REG_NUM), register address width
NUM_SRC, 3, source operands checked per instruction (rs1, rs2, rs3 for fused FP)
LAT_W, 3, width of the latency field and of each scoreboard counter (max latency 2^LAT_W-1)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
branch_sel  in  2  PC select from EXE; 2'b00 = PC+4, anything else = taken/jump
mem_stall  in  1  IM/DM not ready; freezes the whole pipeline
id_valid  in  1  ID holds a real instruction
id_rs_addr  in  NUM_SRC*ADDR_W  packed source addresses, src0 in LSBs
id_rs_used  in  NUM_SRC  per-source read enable
id_rd_addr  in  ADDR_W  destination of ID instruction
id_rd_we  in  1  ID instruction writes rd
id_lat  in  LAT_W  cycles until result is forwardable; 0 = ALU (no tracking), 1 = load
wb_clr_valid  in  1  early completion (e.g. divider finished early)
wb_clr_addr  in  ADDR_W  register cleared by wb_clr_valid
pc_write  out  1  PC update enable
instr_flush  out  1  flush IF/ID instruction
IF_ID_reg_write  out  1  IF/ID register enable
ctrl_sig_flush  out  1  zero ID/EXE control signals (insert bubble)
lw_use  out  1  RAW/WAW stall this cycle (for CSR/perf)
busy_vec  out  REG_NUM  bit i = counter[i] != 0
stall_cnt  out  32  RAW/WAW stall-cycle count

Behaviour:
- Reset (async, rst_n=0): all counters 0, busy_vec 0, stall_cnt 0. Combinational outputs follow the rules below with empty scoreboard: pc_write=1, IF_ID_reg_write=1, flushes=0, lw_use=0.
- hazard (comb) = id_valid and (any src i with id_rs_used[i], addr!=0, counter[addr]!=0, or id_rd_we, rd!=0, counter[rd]!=0 (WAW)).
- Output priority, highest first:
  1. mem_stall=1: pc_write=0, IF_ID_reg_write=0, instr_flush=0, ctrl_sig_flush=0, lw_use=0. All counters hold (no decrement, no set, no clear except wb_clr).
  2. branch_sel!=00: pc_write=1, IF_ID_reg_write=1, instr_flush=1, ctrl_sig_flush=1, lw_use=0. ID instruction is killed and does not set the scoreboard.
  3. hazard: pc_write=0, IF_ID_reg_write=0, instr_flush=0, ctrl_sig_flush=1, lw_use=1.
  4. Else all enables 1, flushes 0, lw_use=0.
- Issue = id_valid and not (mem_stall or branch or hazard).
- Per-counter next state, in priority order:
  - Set to id_lat on issue with id_rd_we, rd!=0, id_lat!=0.
  - Else 0 on wb_clr_valid matching.
  - Else decrement if nonzero and not mem_stall.
- Set beats clear on the same register in the same cycle.
- Counter 0 is constant zero.
- Load example: load issues at cycle t (counter=1). The dependent instruction in ID at t+1 stalls one cycle; counter reaches 0 at t+2 and the dependent issues. This matches a one-bubble load-use.
- stall_cnt increments on cycles with lw_use=1 and saturates at 2^32-1.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: stall_cnt register implemented as above.
- Undefined: no counter flops, stall_cnt tied to 0.
- All other behaviour is identical in both builds.

Decomposition:
- hazard_pkg holds:
  - the branch_sel encoding enum (PC_4=2'b00, BRANCH, JALR, JAL)
  - the LAT_W default and latency constants (LAT_ALU=0, LAT_LOAD=1, LAT_MUL, LAT_DIV, LAT_FP)
  - a hazard_ctrl_t struct bundling the four control outputs
- Sub-module hazard_sb_entry: one countdown counter with set/clear/hold/decrement. It is generated for registers 1..REG_NUM-1.

Test Plan:
- Load x5 (lat 1), then add x6,x5,x1 -> exactly one cycle of pc_write=0, ctrl_sig_flush=1, lw_use=1; add issues next cycle; stall_cnt=1.
- DIV x7 (lat 6), then use x7 immediately -> 6 stall cycles. Repeat with wb_clr_valid on x7 after 2 cycles -> stall ends at the next cycle.
- Load x5 followed by branch_sel=01 in the same cycle the use sits in ID -> flush wins: instr_flush=1, ctrl_sig_flush=1, lw_use=0, stall_cnt unchanged.
- mem_stall=1 for 3 cycles while x8 counter=2 -> all enables 0, counter stays 2; after release, 2 more cycles before x8 is free.
- Instruction with rd=x0 and lat 4, then reads of x0 -> no set, no stall. WAW: MUL x9 (lat 3) then ALU writing x9 -> stall until counter=0.
- Assert rst_n low mid-DIV stall -> busy_vec=0 and pc_write=1 immediately (async), stall_cnt=0.
